// File: rtl/hazard_stall_ctrl.sv
// Load-use / multi-cycle-EX hazard controller for the 5-stage RV32I pipeline.
// Drives PC, IF/ID, ID/EX hold and bubble controls; counts front-end stall cycles.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MDIV_LAT   = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic                  id_ex_multicycle,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  if_idWrite,
  output logic                  controltomux,
  output logic                  if_id_flush,
  output logic                  ex_busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int  MAX_LAT = (LOAD_LAT > MDIV_LAT) ? LOAD_LAT : MDIV_LAT;
  localparam int  CW      = $clog2(MAX_LAT) + 1;
  localparam bit  MC_STALL = (MDIV_LAT > 1);
  localparam bit  MC_LONG  = (MDIV_LAT > 2);
  localparam bit  LD_LONG  = (LOAD_LAT > 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_STALL,
    MC_BUSY
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_next_cnt;
  logic [CNT_W-1:0]    r_stall_count;

  logic [6:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic                  w_rs1_used;
  logic                  w_rs2_used;
  logic                  w_hit;
  logic                  w_unused_instr;

  assign w_opcode       = instr[6:0];
  assign w_rs1          = REG_ADDR_W'(instr[19:15]);
  assign w_rs2          = REG_ADDR_W'(instr[24:20]);
  assign w_unused_instr = ^{instr[31:25], instr[14:7]};

  assign w_rs1_used = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
  assign w_rs2_used = (w_opcode == OP_R) || (w_opcode == OP_S) || (w_opcode == OP_B);

  assign w_hit = id_valid && (id_ex_rd != '0) &&
                 ((w_rs1_used && (w_rs1 == id_ex_rd)) || (w_rs2_used && (w_rs2 == id_ex_rd)));

  // The first stall cycle is decided combinationally in IDLE; the counter covers the rest.
  always_comb begin
    pc_write     = 1'b1;
    if_idWrite   = 1'b1;
    controltomux = 1'b0;
    if_id_flush  = 1'b0;
    ex_busy      = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;

    case (r_state)
      IDLE: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          controltomux = 1'b1;
        end else if (id_ex_multicycle && MC_STALL) begin
          pc_write   = 1'b0;
          if_idWrite = 1'b0;
          ex_busy    = 1'b1;
          if (MC_LONG) begin
            w_next_state = MC_BUSY;
            w_next_cnt   = CW'(MDIV_LAT - 2);
          end
        end else if (id_ex_memread && w_hit) begin
          pc_write     = 1'b0;
          if_idWrite   = 1'b0;
          controltomux = 1'b1;
          if (LD_LONG) begin
            w_next_state = LOAD_STALL;
            w_next_cnt   = CW'(LOAD_LAT - 1);
          end
        end
      end

      LOAD_STALL: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          controltomux = 1'b1;
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else begin
          pc_write     = 1'b0;
          if_idWrite   = 1'b0;
          controltomux = 1'b1;
          w_next_cnt   = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_next_state = IDLE;
        end
      end

      MC_BUSY: begin
        pc_write   = 1'b0;
        if_idWrite = 1'b0;
        ex_busy    = 1'b1;
        w_next_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase

    if (reset) begin
      pc_write     = 1'b1;
      if_idWrite   = 1'b1;
      controltomux = 1'b0;
      if_id_flush  = 1'b0;
      ex_busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (!pc_write && (r_stall_count != '1)) r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4, both MDIV_LAT=4) share stimulus; outputs checked per cycle.
module tb_hazard_stall_ctrl;

  localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333;
  localparam logic [31:0] ADDI_RS2F_5  = 32'h00508313;
  localparam logic [31:0] LUI_RS1F_5   = 32'h000284B7;
  localparam logic [31:0] SW_X5        = 32'h0050A023;
  localparam logic [31:0] NOP          = 32'h00000013;

  // {pc_write, if_idWrite, controltomux, if_id_flush, ex_busy}
  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_LOAD  = 5'b00100;
  localparam logic [4:0] O_MC    = 5'b00001;
  localparam logic [4:0] O_FLUSH = 5'b11110;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        id_valid;
  logic [4:0]  id_ex_rd;
  logic        id_ex_memread;
  logic        id_ex_multicycle;
  logic        branch_taken;

  logic        a_pc, a_ifid, a_ctm, a_flush, a_busy;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_ctm, b_flush, b_busy;
  logic [3:0]  b_cnt;
  logic [4:0]  w_oa, w_ob;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign w_oa = {a_pc, a_ifid, a_ctm, a_flush, a_busy};
  assign w_ob = {b_pc, b_ifid, b_ctm, b_flush, b_busy};

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .MDIV_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .instr(instr), .id_valid(id_valid), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .id_ex_multicycle(id_ex_multicycle),
    .branch_taken(branch_taken), .pc_write(a_pc), .if_idWrite(a_ifid),
    .controltomux(a_ctm), .if_id_flush(a_flush), .ex_busy(a_busy), .stall_count(a_cnt)
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .MDIV_LAT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .instr(instr), .id_valid(id_valid), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .id_ex_multicycle(id_ex_multicycle),
    .branch_taken(branch_taken), .pc_write(b_pc), .if_idWrite(b_ifid),
    .controltomux(b_ctm), .if_id_flush(b_flush), .ex_busy(b_busy), .stall_count(b_cnt)
  );

  // A taken branch must never coincide with a multi-cycle op still draining in EX.
  always @(negedge clk)
    if (!reset && branch_taken && b_busy && !id_ex_multicycle)
      $error("branch_taken asserted while MC_BUSY");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr = NOP; id_valid = 1'b0; id_ex_rd = 5'd0;
    id_ex_memread = 1'b0; id_ex_multicycle = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_hazard(input logic [31:0] ins);
    instr = ins; id_valid = 1'b1; id_ex_rd = 5'd5; id_ex_memread = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_hazard(ADD_X6_X5_X7);
    id_ex_multicycle = 1'b1;
    @(negedge clk);
    n_vec++; if (w_oa !== O_IDLE) begin n_err++; $display("FAIL reset_out_a got %b want %b", w_oa, O_IDLE); end
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL reset_out_b got %b want %b", w_ob, O_IDLE); end
    tick();
    @(negedge clk);
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt_a got %0d want 0", a_cnt); end
    n_vec++; if (b_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt_b got %0d want 0", b_cnt); end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_hazard(ADD_X6_X5_X7);
    @(negedge clk);
    n_vec++; if (w_oa !== O_LOAD) begin n_err++; $display("FAIL lu_c1_a got %b want %b", w_oa, O_LOAD); end
    n_vec++; if (w_ob !== O_LOAD) begin n_err++; $display("FAIL lu_c1_b got %b want %b", w_ob, O_LOAD); end
    tick();
    id_ex_memread = 1'b0; id_ex_rd = 5'd0;
    @(negedge clk);
    n_vec++; if (w_oa !== O_IDLE) begin n_err++; $display("FAIL lu_c2_a got %b want %b", w_oa, O_IDLE); end
    n_vec++; if (w_ob !== O_LOAD) begin n_err++; $display("FAIL lu_c2_b got %b want %b", w_ob, O_LOAD); end
    tick();
    @(negedge clk);
    n_vec++; if (w_ob !== O_LOAD) begin n_err++; $display("FAIL lu_c3_b got %b want %b", w_ob, O_LOAD); end
    tick();
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL lu_c4_b got %b want %b", w_ob, O_IDLE); end
    n_vec++; if (a_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt_a got %0d want 1", a_cnt); end
    n_vec++; if (b_cnt !== 4'd3) begin n_err++; $display("FAIL lu_cnt_b got %0d want 3", b_cnt); end
    tick();
  endtask

  task automatic test_no_stall();
    do_reset();
    set_hazard(ADD_X6_X5_X7);
    id_ex_rd = 5'd0;
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL ns_rd0 got %b want %b", w_ob, O_IDLE); end
    tick();
    set_hazard(ADDI_RS2F_5);
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL ns_addi got %b want %b", w_ob, O_IDLE); end
    tick();
    set_hazard(LUI_RS1F_5);
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL ns_lui got %b want %b", w_ob, O_IDLE); end
    tick();
    set_hazard(ADD_X6_X5_X7);
    id_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (w_oa !== O_IDLE) begin n_err++; $display("FAIL ns_invalid got %b want %b", w_oa, O_IDLE); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (b_cnt !== 4'd0) begin n_err++; $display("FAIL ns_cnt_b got %0d want 0", b_cnt); end
    tick();
  endtask

  task automatic test_store();
    do_reset();
    set_hazard(SW_X5);
    @(negedge clk);
    n_vec++; if (w_oa !== O_LOAD) begin n_err++; $display("FAIL sw_c1_a got %b want %b", w_oa, O_LOAD); end
    tick();
    id_ex_memread = 1'b0; id_ex_rd = 5'd0;
    @(negedge clk);
    n_vec++; if (w_oa !== O_IDLE) begin n_err++; $display("FAIL sw_c2_a got %b want %b", w_oa, O_IDLE); end
    tick();
    tick();
    @(negedge clk);
    n_vec++; if (a_cnt !== 16'd1) begin n_err++; $display("FAIL sw_cnt_a got %0d want 1", a_cnt); end
    tick();
  endtask

  task automatic test_multicycle();
    do_reset();
    id_ex_multicycle = 1'b1;
    @(negedge clk);
    n_vec++; if (w_oa !== O_MC) begin n_err++; $display("FAIL mc_c1_a got %b want %b", w_oa, O_MC); end
    tick();
    id_ex_multicycle = 1'b0;
    set_hazard(ADD_X6_X5_X7);
    branch_taken = 1'b0;
    @(negedge clk);
    n_vec++; if (w_oa !== O_MC) begin n_err++; $display("FAIL mc_c2_a got %b want %b", w_oa, O_MC); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (w_ob !== O_MC) begin n_err++; $display("FAIL mc_c3_b got %b want %b", w_ob, O_MC); end
    tick();
    @(negedge clk);
    n_vec++; if (w_oa !== O_IDLE) begin n_err++; $display("FAIL mc_c4_a got %b want %b", w_oa, O_IDLE); end
    n_vec++; if (a_cnt !== 16'd3) begin n_err++; $display("FAIL mc_cnt_a got %0d want 3", a_cnt); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    set_hazard(ADD_X6_X5_X7);
    tick();
    id_ex_memread = 1'b0; id_ex_rd = 5'd0;
    branch_taken = 1'b1;
    @(negedge clk);
    n_vec++; if (w_ob !== O_FLUSH) begin n_err++; $display("FAIL br_ls_b got %b want %b", w_ob, O_FLUSH); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL br_after_b got %b want %b", w_ob, O_IDLE); end
    n_vec++; if (b_cnt !== 4'd1) begin n_err++; $display("FAIL br_cnt_b got %0d want 1", b_cnt); end
    tick();
    do_reset();
    set_hazard(ADD_X6_X5_X7);
    branch_taken = 1'b1;
    @(negedge clk);
    n_vec++; if (w_oa !== O_FLUSH) begin n_err++; $display("FAIL br_hit_a got %b want %b", w_oa, O_FLUSH); end
    n_vec++; if (w_ob !== O_FLUSH) begin n_err++; $display("FAIL br_hit_b got %b want %b", w_ob, O_FLUSH); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL br_hit_next_b got %b want %b", w_ob, O_IDLE); end
    tick();
  endtask

  task automatic test_reset_mid_mc();
    do_reset();
    id_ex_multicycle = 1'b1;
    tick();
    id_ex_multicycle = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL rmc_forced_b got %b want %b", w_ob, O_IDLE); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (w_ob !== O_IDLE) begin n_err++; $display("FAIL rmc_after_b got %b want %b", w_ob, O_IDLE); end
    n_vec++; if (b_cnt !== 4'd0) begin n_err++; $display("FAIL rmc_cnt_b got %0d want 0", b_cnt); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    id_ex_multicycle = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    n_vec++; if (b_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt_b got %0d want 15", b_cnt); end
    n_vec++; if (a_cnt !== 16'd20) begin n_err++; $display("FAIL sat_cnt_a got %0d want 20", a_cnt); end
    tick();
    @(negedge clk);
    n_vec++; if (b_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold_b got %0d want 15", b_cnt); end
    tick();
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    test_reset();
    test_load_use();
    test_no_stall();
    test_store();
    test_multicycle();
    test_branch();
    test_reset_mid_mc();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
